// File: rtl/bayer_capture_sequencer_if.sv
// Pixel stream between the sensor input register stage, the capture sequencer and the
// Bayer converter. The master drives the raw sensor side; the slave is the sequencer.
interface bayer_capture_sequencer_if;
  logic        iFVAL;
  logic        iLVAL;
  logic [11:0] iDATA;
  logic [11:0] oDATA;
  logic        oDVAL;
  logic [10:0] oX_Cont;
  logic [10:0] oY_Cont;

  modport master (
    output iFVAL, iLVAL, iDATA,
    input  oDATA, oDVAL, oX_Cont, oY_Cont
  );

  modport slave (
    input  iFVAL, iLVAL, iDATA,
    output oDATA, oDVAL, oX_Cont, oY_Cont
  );
endinterface

// File: rtl/bayer_capture_sequencer.sv
// Frame-aligned capture sequencer: arming, frame decimation, X/Y counters, length checks.
// Optional crop window is enabled with `BAYER_SEQ_CROP_EN.
module bayer_capture_sequencer #(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 960,
  parameter int CROP_X0  = 0,
  parameter int CROP_Y0  = 0,
  parameter int CROP_W   = 640,
  parameter int CROP_H   = 480
) (
  input  logic                              iCLK,
  input  logic                              iRST,
  input  logic                              iSTART,
  input  logic                              iSTOP,
  input  logic [3:0]                        iSKIP,
  bayer_capture_sequencer_if.slave          px,
  output logic [31:0]                       oFrame_Cont,
  output logic                              oBUSY,
  output logic                              oERR
);

  localparam logic [10:0] XY_MAX = 11'h7FF;

  // Odd crop origins or sizes would flip the Bayer phase of the output window.
  if ((CROP_X0 % 2) != 0 || (CROP_Y0 % 2) != 0 || (CROP_W % 2) != 0 || (CROP_H % 2) != 0) begin : g_crop_odd
    $error("bayer_capture_sequencer: crop origin and size must be even");
  end

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_SKIP} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_fval_d, r_lval_d, r_stop_pend, r_err, r_dval;
  logic [3:0]  r_skip;
  logic [10:0] r_x, r_y, r_ox, r_oy;
  logic [11:0] r_data;
  logic [31:0] r_frame;

  logic        w_fval_rise, w_fval_fall, w_lval_fall, w_pix, w_stop;
  logic        w_load_skip, w_dec_skip, w_frame_done, w_capture;
  logic        w_y_inc, w_err_set, w_win;
  logic [10:0] w_x_cur, w_y_cur, w_y_fin, w_xo, w_yo;

  assign w_fval_rise = px.iFVAL & ~r_fval_d;
  assign w_fval_fall = ~px.iFVAL & r_fval_d;
  assign w_lval_fall = ~px.iLVAL & r_lval_d;
  assign w_pix       = px.iFVAL & px.iLVAL;
  assign w_stop      = r_stop_pend | iSTOP;

  always_comb begin
    w_state_nxt  = r_state;
    w_load_skip  = 1'b0;
    w_dec_skip   = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      S_IDLE:
        if (!iSTOP && iSTART) w_state_nxt = S_ARMED;
      S_ARMED:
        if (iSTOP) w_state_nxt = S_IDLE;
        else if (w_fval_rise) begin
          if (r_skip == 4'd0) begin
            w_state_nxt = S_CAPTURE;
            w_load_skip = 1'b1;
          end else begin
            w_state_nxt = S_SKIP;
          end
        end
      S_CAPTURE:
        if (w_fval_fall) begin
          w_frame_done = 1'b1;
          w_state_nxt  = w_stop ? S_IDLE : S_ARMED;
        end
      S_SKIP:
        if (w_fval_fall) begin
          w_dec_skip  = 1'b1;
          w_state_nxt = w_stop ? S_IDLE : S_ARMED;
        end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The frame-start cycle itself already belongs to the captured frame.
  assign w_capture = (r_state == S_CAPTURE) | w_load_skip;

  assign w_x_cur = w_fval_rise ? 11'd0 : r_x;
  assign w_y_cur = w_fval_rise ? 11'd0 : r_y;
  assign w_y_inc = w_lval_fall && (r_x != 11'd0) && (r_y != XY_MAX);
  // Row count as it stands after this cycle, so a line ending on the frame's last cycle counts.
  assign w_y_fin = w_y_inc ? r_y + 11'd1 : r_y;

  assign w_err_set = (r_state == S_CAPTURE) &&
                     ((w_lval_fall && (r_x != 11'(H_ACTIVE))) ||
                      (w_fval_fall && (w_y_fin != 11'(V_ACTIVE))));

`ifdef BAYER_SEQ_CROP_EN
  logic [11:0] w_xr, w_yr;
  // Left of / above the window the subtraction wraps to a large value and fails the compare.
  assign w_xr  = {1'b0, w_x_cur} - 12'(CROP_X0);
  assign w_yr  = {1'b0, w_y_cur} - 12'(CROP_Y0);
  assign w_win = !w_xr[11] && !w_yr[11] && (w_xr < 12'(CROP_W)) && (w_yr < 12'(CROP_H));
  assign w_xo  = w_xr[10:0];
  assign w_yo  = w_yr[10:0];
`else
  assign w_win = 1'b1;
  assign w_xo  = w_x_cur;
  assign w_yo  = w_y_cur;
`endif

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_state     <= S_IDLE;
      r_fval_d    <= 1'b0;
      r_lval_d    <= 1'b0;
      r_stop_pend <= 1'b0;
      r_skip      <= 4'd0;
      r_frame     <= 32'd0;
      r_err       <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_fval_d <= px.iFVAL;
      r_lval_d <= px.iLVAL;
      if (w_state_nxt == S_IDLE || w_state_nxt == S_ARMED) r_stop_pend <= 1'b0;
      else if (iSTOP)                                      r_stop_pend <= 1'b1;
      if (w_load_skip)                         r_skip <= iSKIP;
      else if (w_dec_skip && r_skip != 4'd0)   r_skip <= r_skip - 4'd1;
      if (w_frame_done) r_frame <= r_frame + 32'd1;
      if (w_err_set)    r_err <= 1'b1;
      else if (iSTART)  r_err <= 1'b0;
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_x <= 11'd0;
      r_y <= 11'd0;
    end else begin
      if (w_pix)                           r_x <= (w_x_cur == XY_MAX) ? XY_MAX : w_x_cur + 11'd1;
      else if (w_lval_fall || w_fval_rise) r_x <= 11'd0;
      if (w_fval_rise)  r_y <= 11'd0;
      else if (w_y_inc) r_y <= r_y + 11'd1;
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_dval <= 1'b0;
      r_data <= 12'd0;
      r_ox   <= 11'd0;
      r_oy   <= 11'd0;
    end else begin
      r_dval <= w_capture & w_pix & w_win;
      if (w_pix) begin
        r_data <= px.iDATA;
        r_ox   <= w_xo;
        r_oy   <= w_yo;
      end
    end
  end

  assign px.oDATA    = r_data;
  assign px.oDVAL    = r_dval;
  assign px.oX_Cont  = r_ox;
  assign px.oY_Cont  = r_oy;
  assign oFrame_Cont = r_frame;
  assign oBUSY       = (r_state != S_IDLE);
  assign oERR        = r_err;

endmodule

// File: tb/tb_bayer_capture_sequencer.sv
// Directed bench for bayer_capture_sequencer on a reduced 8x4 frame geometry.
module tb_bayer_capture_sequencer;
  localparam int H = 8;
  localparam int V = 4;
`ifdef BAYER_SEQ_CROP_EN
  localparam int CX0 = 2, CY0 = 2, CW = 4, CH = 2;
  localparam bit CROP = 1'b1;
`else
  localparam int CX0 = 0, CY0 = 0, CW = H, CH = V;
  localparam bit CROP = 1'b0;
`endif
  localparam int EPF = CW * CH;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b0;
  logic        iSTART = 1'b0;
  logic        iSTOP = 1'b0;
  logic [3:0]  iSKIP = 4'd0;
  logic [31:0] oFrame_Cont;
  logic        oBUSY, oERR;

  bayer_capture_sequencer_if px();

  bayer_capture_sequencer #(
    .H_ACTIVE(H), .V_ACTIVE(V), .CROP_X0(CX0), .CROP_Y0(CY0), .CROP_W(CW), .CROP_H(CH)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iSTOP(iSTOP), .iSKIP(iSKIP),
    .px(px), .oFrame_Cont(oFrame_Cont), .oBUSY(oBUSY), .oERR(oERR)
  );

  always #5 iCLK = ~iCLK;

  int n_vec = 0;
  int n_err = 0;
  int m_cnt = 0;
  bit m_seen = 1'b0;
  logic [10:0] m_fx, m_fy, m_lx, m_ly;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] pat(input int y, input int x);
    logic [11:0] v;
    v = 12'((y << 6) | x);
    return v ^ 12'hA5A;
  endfunction

  always @(negedge iCLK) begin
    if (px.oDVAL === 1'b1) begin
      if (!m_seen) begin
        m_fx   = px.oX_Cont;
        m_fy   = px.oY_Cont;
        m_seen = 1'b1;
      end
      m_lx = px.oX_Cont;
      m_ly = px.oY_Cont;
      m_cnt++;
      chk("pix_data", 32'(px.oDATA), 32'(pat(int'(px.oY_Cont) + CY0, int'(px.oX_Cont) + CX0)));
    end
  end

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic clr_mon();
    m_cnt  = 0;
    m_seen = 1'b0;
  endtask

  task automatic pulse_start();
    iSTART = 1'b1; step(); iSTART = 1'b0;
  endtask

  task automatic pulse_stop();
    iSTOP = 1'b1; step(); iSTOP = 1'b0;
  endtask

  // short_ln: that line carries H-1 pixels; start_ln/stop_ln: pulse on that line's first pixel.
  task automatic drive_frame(input int nl, input int short_ln, input int start_ln, input int stop_ln);
    px.iFVAL = 1'b1; step(); step();
    for (int ln = 0; ln < nl; ln++) begin
      for (int c = 0; c < ((ln == short_ln) ? H - 1 : H); c++) begin
        px.iLVAL = 1'b1;
        px.iDATA = pat(ln, c);
        iSTART   = (c == 0 && ln == start_ln);
        iSTOP    = (c == 0 && ln == stop_ln);
        step();
      end
      px.iLVAL = 1'b0; iSTART = 1'b0; iSTOP = 1'b0;
      step(); step();
    end
    px.iFVAL = 1'b0;
    step(); step(); step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    px.iFVAL = 1'b0; px.iLVAL = 1'b0; px.iDATA = 12'd0;
    step(); step();
    chk("rst_dval",  32'(px.oDVAL), 0);
    chk("rst_busy",  32'(oBUSY), 0);
    chk("rst_err",   32'(oERR), 0);
    chk("rst_frame", oFrame_Cont, 0);
    chk("rst_x",     32'(px.oX_Cont), 0);
    chk("rst_y",     32'(px.oY_Cont), 0);
    chk("rst_data",  32'(px.oDATA), 0);
    iRST = 1'b1; step();

    // two full captured frames
    pulse_start();
    chk("t1_busy", 32'(oBUSY), 1);
    clr_mon();
    drive_frame(V, -1, -1, -1);
    drive_frame(V, -1, -1, -1);
    chk("t1_frame", oFrame_Cont, 2);
    chk("t1_cnt",   m_cnt, 2 * EPF);
    chk("t1_fx",    32'(m_fx), 0);
    chk("t1_fy",    32'(m_fy), 0);
    chk("t1_lx",    32'(m_lx), CW - 1);
    chk("t1_ly",    32'(m_ly), CH - 1);
    chk("t1_err",   32'(oERR), 0);

    // stop while armed, then re-arm in the middle of a frame
    pulse_stop();
    chk("t2_idle", 32'(oBUSY), 0);
    clr_mon();
    drive_frame(V, -1, 1, -1);
    chk("t2_partial_cnt", m_cnt, 0);
    chk("t2_busy",        32'(oBUSY), 1);
    clr_mon();
    drive_frame(V, -1, -1, -1);
    chk("t2_cnt",   m_cnt, EPF);
    chk("t2_fx",    32'(m_fx), 0);
    chk("t2_fy",    32'(m_fy), 0);
    chk("t2_frame", oFrame_Cont, 3);

    // decimation: skip 2 between captures over 6 frames
    iSKIP = 4'd2;
    for (int f = 0; f < 6; f++) begin
      clr_mon();
      drive_frame(V, -1, -1, -1);
      chk($sformatf("t3_f%0d_cnt", f), m_cnt, (f == 0 || f == 3) ? EPF : 0);
    end
    chk("t3_frame", oFrame_Cont, 5);
    iSKIP = 4'd0;

    // short line -> sticky error, cleared by iSTART while busy
    chk("t4_err_pre", 32'(oERR), 0);
    drive_frame(V, 1, -1, -1);
    chk("t4_err_line",  32'(oERR), 1);
    chk("t4_frame",     oFrame_Cont, 6);
    drive_frame(V, -1, -1, -1);
    chk("t4_err_stick", 32'(oERR), 1);
    chk("t4_frame2",    oFrame_Cont, 7);
    pulse_start();
    chk("t4_err_clr",   32'(oERR), 0);
    chk("t4_busy",      32'(oBUSY), 1);
    drive_frame(V - 1, -1, -1, -1);
    chk("t4_err_frame", 32'(oERR), 1);
    chk("t4_frame3",    oFrame_Cont, 8);
    pulse_start();
    chk("t4_err_clr2",  32'(oERR), 0);

    // stop during a captured frame lets it finish
    clr_mon();
    drive_frame(V, -1, -1, 2);
    chk("t5_cnt",   m_cnt, EPF);
    chk("t5_frame", oFrame_Cont, 9);
    chk("t5_busy",  32'(oBUSY), 0);
    clr_mon();
    drive_frame(V, -1, -1, -1);
    chk("t5_idle_cnt", m_cnt, 0);
    chk("t5_frame2",   oFrame_Cont, 9);

    // start and stop together: stop wins
    iSTART = 1'b1; iSTOP = 1'b1; step();
    iSTART = 1'b0; iSTOP = 1'b0; step();
    chk("t6_busy", 32'(oBUSY), 0);

    // reset in the middle of a captured line
    pulse_start();
    px.iFVAL = 1'b1; step(); step();
    for (int c = 0; c < 3; c++) begin
      px.iLVAL = 1'b1; px.iDATA = pat(0, c); step();
    end
    chk("t7_pre_dval", 32'(px.oDVAL), CROP ? 0 : 1);
    iRST = 1'b0; #1;
    chk("t7_dval",  32'(px.oDVAL), 0);
    chk("t7_busy",  32'(oBUSY), 0);
    chk("t7_frame", oFrame_Cont, 0);
    step(); iRST = 1'b1;
    for (int c = 3; c < H; c++) begin
      px.iDATA = pat(0, c); step();
    end
    px.iLVAL = 1'b0; step();
    px.iFVAL = 1'b0; step(); step();
    clr_mon();
    drive_frame(V, -1, -1, -1);
    chk("t7_cnt",   m_cnt, 0);
    chk("t7_idle",  32'(oBUSY), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
